c2_channel_packer: RTL and testbench
====================================

# c2_channel_packer

Repacks the serialized conv2 output into per-pixel words for the next layer. The conv layer emits one 16-bit post-ReLU value per cycle, channel by channel. This block gathers NUM_CH consecutive values into one packed pixel word, with channel k in lane k (bits [32k+31:32k]). That is the same packing the conv layers consume on their input. Complete words are buffered in a first-word-fall-through FIFO and delivered over a valid/ready handshake, tagged with end-of-row and end-of-frame flags.

## Interface
Parameters:
- NUM_CH, 3, channels per pixel word
- IN_W, 16, input value width
- LANE_W, 32, output lane width per channel
- DEPTH, 16, FIFO depth in words (power of two)
- AF_LEVEL, 14, fill level at which almost_full asserts
- OUT_W, 11, pixels per output row
- OUT_H, 11, rows per frame

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high
- frame_start  in  1  single-cycle pulse; resynchronizes packing and counters
- ch_data  in  IN_W  one channel value
- ch_valid  in  1  ch_data valid this cycle
- data_out  out  NUM_CH*LANE_W  packed pixel word at FIFO head
- data_out_valid  out  1  FIFO non-empty
- data_out_ready  in  1  downstream accepts
- data_out_eol  out  1  head word is the last pixel of a row
- data_out_eof  out  1  head word is the last pixel of the frame
- fifo_count  out  $clog2(DEPTH)+1  current occupancy
- almost_full  out  1  fifo_count >= AF_LEVEL
- overflow  out  1  sticky: a completed word was dropped
- partial_err  out  1  sticky: frame_start arrived with a partial word pending

## Operation
- Channel counter ch_cnt counts 0..NUM_CH-1 and advances on each ch_valid.
  - ch_data is zero-extended to LANE_W and written to lane ch_cnt of the assembly register.
  - The value is non-negative by construction, so no sign extension is applied.
- Push: on the ch_valid where ch_cnt==NUM_CH-1, the assembled word, including the current beat, is pushed. ch_cnt then wraps to 0.
- Push acceptance:
  - Accepted if fifo_count<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped and overflow is set to 1. overflow stays high until reset.
- Pop: occurs when data_out_valid && data_out_ready. The read pointer advances.
- Simultaneous push and pop leaves fifo_count unchanged.
- Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.
- Output position counters:
  - x_out runs 0..OUT_W-1 and y_out runs 0..OUT_H-1. Both advance on pop only.
  - data_out_eol = (x_out==OUT_W-1).
  - data_out_eof = eol && (y_out==OUT_H-1).
  - Both flags are combinational from the counters and are gated by data_out_valid.
  - After the eof pop, both counters return to 0.
- frame_start:
  - Clears ch_cnt and the assembly register.
  - If ch_cnt!=0 at that moment, partial_err is set to 1 (sticky).
  - Does not flush the FIFO and does not reset x_out/y_out, which are tied to words already buffered.
  - If ch_valid coincides with frame_start, the beat is taken as channel 0 of the new word.
- No state machine beyond the counters. The assembly state is implicitly IDLE when ch_cnt==0 and FILLING otherwise.

## Timing
- Reset values:
  - data_out=0, data_out_valid=0, eol=0, eof=0, fifo_count=0, almost_full=0, overflow=0, partial_err=0.
  - Internal: ch_cnt=0, x_out=0, y_out=0.
- Reset asserted mid-operation discards all buffered and partial data immediately (asynchronous).
- Latency: the last-channel beat is sampled at edge N. data_out_valid=1 and data_out holds the word after edge N, i.e. a 1-cycle latency to an empty FIFO.
- data_out, eol and eof remain stable while data_out_valid && !data_out_ready.
- fifo_count, almost_full and overflow are registered and update after the causing edge.
- Sustained throughput: one word per NUM_CH input beats. Output can pop one word per cycle.
- The upstream layer has no ready input. almost_full is the upstream stall hint, and must assert early enough that AF_LEVEL leaves DEPTH-AF_LEVEL words of headroom.

## Test plan
- Basic pack: ch_data 0x0012, 0x0034, 0x0056 on consecutive cycles, ready=1 → the next cycle shows data_out = {32'h56,32'h34,32'h12}, valid=1 for 1 cycle, fifo_count back to 0.
- Backpressure and overflow: ready=0, push 17 words → almost_full=1 after the 14th, fifo_count=16, the 17th is dropped, overflow=1. Then ready=1 drains words 1..16 in order.
- Full plus simultaneous pop and push: FIFO at 16, ready=1 in the same cycle as a completing beat → word accepted, fifo_count stays 16, overflow stays 0.
- Frame tagging: 121 words with ready toggling pseudo-randomly → eol on pops 11, 22, …, 121 and eof only on pop 121. The next frame's first pop has eol=eof=0.
- Partial resync: 2 beats, then frame_start → partial_err=1, no word pushed. The next 3 beats 0x1,0x2,0x3 yield {32'h3,32'h2,32'h1}.
- Reset mid-stream: 5 words buffered, with ch_cnt=1, assert rst_n → all outputs at reset values. After release, 3 beats produce exactly one word.

Source files
------------

// File: rtl/c2_channel_packer.sv
// c2_channel_packer
//   Gathers NUM_CH consecutive post-ReLU channel values into one packed pixel
//   word (channel k in lane k, zero-extended to LANE_W bits) and buffers the
//   words in a first-word-fall-through FIFO. Words leave over a valid/ready
//   handshake, tagged with end-of-row / end-of-frame flags derived from the
//   output pixel position.
//
// Ports:
//   clk             clock
//   rst_n           asynchronous reset, active-high (asserted when 1)
//   frame_start     single-cycle pulse, restarts word assembly
//   ch_data         one channel value
//   ch_valid        ch_data valid this cycle
//   data_out        packed pixel word at FIFO head (0 when empty)
//   data_out_valid  FIFO non-empty
//   data_out_ready  downstream accepts the head word
//   data_out_eol    head word is the last pixel of a row
//   data_out_eof    head word is the last pixel of the frame
//   fifo_count      current FIFO occupancy, 0..DEPTH
//   almost_full     fifo_count >= AF_LEVEL (upstream stall hint)
//   overflow        sticky: a completed word was dropped
//   partial_err     sticky: frame_start arrived with a partial word pending
module c2_channel_packer #(
    parameter int unsigned NUM_CH   = 3,
    parameter int unsigned IN_W     = 16,
    parameter int unsigned LANE_W   = 32,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = 14,
    parameter int unsigned OUT_W    = 11,
    parameter int unsigned OUT_H    = 11
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        frame_start,
    input  logic [IN_W-1:0]             ch_data,
    input  logic                        ch_valid,
    output logic [NUM_CH*LANE_W-1:0]    data_out,
    output logic                        data_out_valid,
    input  logic                        data_out_ready,
    output logic                        data_out_eol,
    output logic                        data_out_eof,
    output logic [$clog2(DEPTH):0]      fifo_count,
    output logic                        almost_full,
    output logic                        overflow,
    output logic                        partial_err
);

    localparam int unsigned WW    = NUM_CH * LANE_W;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;
    localparam int unsigned CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned XW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int unsigned YW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;

    logic [CW-1:0]    ch_cnt_q, ch_cnt_d;
    logic [WW-1:0]    asm_q, asm_d;
    logic [WW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [XW-1:0]    x_q;
    logic [YW-1:0]    y_q;
    logic             af_q, ovf_q, perr_q;

    logic [CW-1:0]    eff_cnt;
    logic [WW-1:0]    base, push_word;
    logic             last_beat, push_req, push_ok, pop;

    // A frame_start beat counts as channel 0 of a fresh word, so the
    // assembly view is cleared combinationally before the beat is merged.
    always_comb begin
        eff_cnt   = frame_start ? '0 : ch_cnt_q;
        base      = frame_start ? '0 : asm_q;
        push_word = base;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (CW'(k) == eff_cnt) begin
                push_word[k*LANE_W +: LANE_W] = LANE_W'(ch_data);
            end
        end
        last_beat = (eff_cnt == CW'(NUM_CH - 1));
        push_req  = ch_valid && last_beat;

        ch_cnt_d = eff_cnt;
        asm_d    = base;
        if (ch_valid) begin
            if (last_beat) begin
                ch_cnt_d = '0;
                asm_d    = '0;
            end else begin
                ch_cnt_d = eff_cnt + CW'(1);
                asm_d    = push_word;
            end
        end
    end

    assign pop     = (count_q != '0) && data_out_ready;
    // A full FIFO still takes the word when the head leaves in the same cycle.
    assign push_ok = push_req && ((count_q != CNT_W'(DEPTH)) || pop);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ch_cnt_q <= '0;
            asm_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            ch_cnt_q <= ch_cnt_d;
            asm_q    <= asm_d;
            count_q  <= count_d;
            af_q     <= (count_d >= CNT_W'(AF_LEVEL));
            if (push_ok) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (push_req && !push_ok) begin
                ovf_q <= 1'b1;
            end
            if (frame_start && (ch_cnt_q != '0)) begin
                perr_q <= 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
                if (x_q == XW'(OUT_W - 1)) begin
                    x_q <= '0;
                    y_q <= (y_q == YW'(OUT_H - 1)) ? '0 : y_q + YW'(1);
                end else begin
                    x_q <= x_q + XW'(1);
                end
            end
        end
    end

    // Storage needs no reset: the head is only visible while count_q != 0.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= push_word;
        end
    end

    assign data_out_valid = (count_q != '0);
    assign data_out       = data_out_valid ? mem_q[rptr_q] : '0;
    assign data_out_eol   = data_out_valid && (x_q == XW'(OUT_W - 1));
    assign data_out_eof   = data_out_eol && (y_q == YW'(OUT_H - 1));
    assign fifo_count     = count_q;
    assign almost_full    = af_q;
    assign overflow       = ovf_q;
    assign partial_err    = perr_q;

endmodule

// File: tb/tb_c2_channel_packer.sv
// Testbench for c2_channel_packer: a stimulus process drives beats and a
// reference model predicts each accepted word (pushed to a scoreboard) plus
// the registered status; a monitor pops and compares on every handshake.
module tb_c2_channel_packer;

    localparam int NUM_CH   = 3;
    localparam int IN_W     = 16;
    localparam int LANE_W   = 32;
    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 14;
    localparam int OUT_W    = 11;
    localparam int OUT_H    = 11;
    localparam int WW       = NUM_CH * LANE_W;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  frame_start = 1'b0;
    logic [IN_W-1:0]       ch_data = '0;
    logic                  ch_valid = 1'b0;
    logic [WW-1:0]         data_out;
    logic                  data_out_valid;
    logic                  data_out_ready = 1'b0;
    logic                  data_out_eol;
    logic                  data_out_eof;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                  almost_full;
    logic                  overflow;
    logic                  partial_err;

    c2_channel_packer #(
        .NUM_CH(NUM_CH), .IN_W(IN_W), .LANE_W(LANE_W), .DEPTH(DEPTH),
        .AF_LEVEL(AF_LEVEL), .OUT_W(OUT_W), .OUT_H(OUT_H)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .ch_data(ch_data), .ch_valid(ch_valid),
        .data_out(data_out), .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready), .data_out_eol(data_out_eol),
        .data_out_eof(data_out_eof), .fifo_count(fifo_count),
        .almost_full(almost_full), .overflow(overflow),
        .partial_err(partial_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WW-1:0] w;
        bit            eol;
        bit            eof;
    } exp_t;

    exp_t            sb[$];
    logic [IN_W-1:0] cur[$];   // beats of the word being assembled
    int              m_cnt  = 0;
    bit              m_ovf  = 0;
    bit              m_perr = 0;
    int              m_pos  = 0; // frame position of the next accepted word
    int              n_cmp  = 0;
    int              n_err  = 0;

    task automatic chk(string name, logic [WW-1:0] act, logic [WW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; model effects are staged and committed
    // after the edge so the monitor always sees the model of the current state.
    task automatic step(bit fs, bit v, logic [IN_W-1:0] d, bit rdy);
        bit            pop, push, accept, n_perr;
        logic [WW-1:0] w;
        frame_start    = fs;
        ch_valid       = v;
        ch_data        = d;
        data_out_ready = rdy;
        pop    = (m_cnt > 0) && rdy;
        push   = 0;
        n_perr = m_perr;
        w      = '0;
        if (fs) begin
            if (cur.size() != 0) n_perr = 1;
            cur.delete();
        end
        if (v) begin
            cur.push_back(d);
            if (cur.size() == NUM_CH) begin
                for (int i = 0; i < NUM_CH; i++) w[i*LANE_W +: LANE_W] = LANE_W'(cur[i]);
                cur.delete();
                push = 1;
            end
        end
        accept = push && ((m_cnt < DEPTH) || pop);
        @(posedge clk);
        #1;
        m_perr = n_perr;
        if (push && !accept) m_ovf = 1;
        m_cnt = m_cnt - (pop ? 1 : 0) + (accept ? 1 : 0);
        if (accept) begin
            exp_t e;
            e.w   = w;
            e.eol = (m_pos % OUT_W) == OUT_W - 1;
            e.eof = (m_pos == OUT_W * OUT_H - 1);
            sb.push_back(e);
            m_pos = (m_pos + 1) % (OUT_W * OUT_H);
        end
    endtask

    task automatic push_words(int n, bit rdy);
        for (int i = 0; i < n; i++)
            for (int c = 0; c < NUM_CH; c++)
                step(0, 1, IN_W'($urandom), rdy);
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH + 4; i++) step(0, 0, '0, 1);
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, ".data"},  data_out, '0);
        chk({tag, ".valid"}, WW'(data_out_valid), '0);
        chk({tag, ".eol"},   WW'(data_out_eol), '0);
        chk({tag, ".eof"},   WW'(data_out_eof), '0);
        chk({tag, ".count"}, WW'(fifo_count), '0);
        chk({tag, ".af"},    WW'(almost_full), '0);
        chk({tag, ".ovf"},   WW'(overflow), '0);
        chk({tag, ".perr"},  WW'(partial_err), '0);
    endtask

    task automatic do_reset(string tag);
        frame_start = 0; ch_valid = 0; data_out_ready = 0;
        rst_n = 1'b1;
        #1;
        chk_reset_outputs(tag);
        m_cnt = 0; m_ovf = 0; m_perr = 0; m_pos = 0;
        cur.delete();
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
    endtask

    // Monitor: registered status against the model, words against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("count", WW'(fifo_count), WW'(m_cnt));
            chk("almost_full", WW'(almost_full), WW'(m_cnt >= AF_LEVEL));
            chk("overflow", WW'(overflow), WW'(m_ovf));
            chk("partial_err", WW'(partial_err), WW'(m_perr));
            chk("valid", WW'(data_out_valid), WW'(m_cnt > 0));
            if (data_out_valid && data_out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", WW'(1), WW'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("data", data_out, e.w);
                    chk("eol", WW'(data_out_eol), WW'(e.eol));
                    chk("eof", WW'(data_out_eof), WW'(e.eof));
                end
            end else if (!data_out_valid) begin
                chk("eol_idle", WW'(data_out_eol), '0);
                chk("eof_idle", WW'(data_out_eof), '0);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset("reset0");

        // Basic pack
        step(0, 1, 16'h0012, 1);
        step(0, 1, 16'h0034, 1);
        step(0, 1, 16'h0056, 1);
        chk("basic.data", data_out, {32'h56, 32'h34, 32'h12});
        chk("basic.valid", WW'(data_out_valid), WW'(1));
        step(0, 0, '0, 1);
        chk("basic.count", WW'(fifo_count), '0);

        // Backpressure and overflow
        push_words(17, 0);
        chk("ovf.count", WW'(fifo_count), WW'(DEPTH));
        chk("ovf.af", WW'(almost_full), WW'(1));
        chk("ovf.flag", WW'(overflow), WW'(1));
        drain();

        // Full plus simultaneous pop and push
        do_reset("reset1");
        push_words(16, 0);
        step(0, 1, 16'h00a1, 0);
        step(0, 1, 16'h00a2, 0);
        step(0, 1, 16'h00a3, 1);
        chk("full_pp.count", WW'(fifo_count), WW'(DEPTH));
        chk("full_pp.ovf", WW'(overflow), '0);
        drain();

        // Frame tagging with random ready
        do_reset("reset2");
        for (int i = 0; i < (OUT_W * OUT_H + 6) * NUM_CH; i++)
            step(0, 1, IN_W'($urandom), 1'($urandom_range(0, 1)));
        drain();

        // Partial resync
        do_reset("reset3");
        step(0, 1, 16'h0007, 1);
        step(0, 1, 16'h0008, 1);
        step(1, 0, '0, 1);
        chk("partial.perr", WW'(partial_err), WW'(1));
        chk("partial.count", WW'(fifo_count), '0);
        step(0, 1, 16'h0001, 1);
        step(0, 1, 16'h0002, 1);
        step(0, 1, 16'h0003, 1);
        chk("partial.data", data_out, {32'h3, 32'h2, 32'h1});
        drain();

        // Coincident frame_start and beat starts a new word at channel 0
        step(0, 1, 16'h00ee, 0);
        step(1, 1, 16'h0011, 0);
        step(0, 1, 16'h0022, 0);
        step(0, 1, 16'h0033, 0);
        chk("fs_beat.data", data_out, {32'h33, 32'h22, 32'h11});
        drain();

        // Reset mid-stream
        push_words(5, 0);
        step(0, 1, 16'hbeef, 0);
        do_reset("reset_mid");
        push_words(1, 0);
        chk("post_reset.count", WW'(fifo_count), WW'(1));
        drain();

        // Random traffic including frame_start pulses
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 29) == 0), 1'($urandom_range(0, 3) != 0),
                 IN_W'($urandom), 1'($urandom_range(0, 2) != 0));
        drain();
        chk("final.sb_empty", WW'(sb.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
